// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter_pkg
// Purpose : Shared types and constants for the two-port SRAM arbiter.
//           - arb_state_e : arbiter FSM state encoding (2 bit)
//           - ARB_M0/ARB_M1 : requester index used to tag read returns
// Revision: 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_M0_RUN  = 2'd1,
        ARB_M1_LOCK = 2'd2
    } arb_state_e;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

endpackage : sram_port_arbiter_pkg
`default_nettype wire

// File: rtl/sram_rd_return.sv
`default_nettype none
// ============================================================================
// Module  : sram_rd_return
// Purpose : One-cycle read-return pipeline. Remembers that a read was issued
//           to the SRAM and by whom, then steers sram_DO to that requester's
//           rdata/rvalid on the following cycle.
// Ports   : clk, reset        - clock, synchronous active-high reset
//           rd_issue, rd_id   - a read was granted this cycle, and to whom
//           sram_DO           - SRAM read data (valid cycle after the read)
//           m0_rvalid/m0_rdata, m1_rvalid/m1_rdata - per-requester return
// Revision: 1.0 - initial release
// ============================================================================
module sram_rd_return
    import sram_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_issue,
    input  logic        rd_id,
    input  logic [31:0] sram_DO,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata
);

    logic valid_d, valid_q;
    logic id_d, id_q;
    logic live;

    always_comb begin
        valid_d = rd_issue;
        id_d    = rd_issue ? rd_id : id_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            id_q    <= ARB_M0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // A read granted just before reset asserts is already in flight in
    // valid_q; masking with reset drops it in the same cycle.
    assign live      = valid_q & ~reset;
    assign m0_rvalid = live & (id_q == ARB_M0);
    assign m1_rvalid = live & (id_q == ARB_M1);
    assign m0_rdata  = m0_rvalid ? sram_DO : 32'd0;
    assign m1_rdata  = m1_rvalid ? sram_DO : 32'd0;

endmodule : sram_rd_return
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_port_arbiter
// Purpose : Shares a single-port 64K x 32 SRAM between M0 (CPU control FSM)
//           and M1 (DMA/loader). Fixed M0 priority, starvation relief for M1
//           after MAX_STREAK contested M0 wins, and an M1 burst lock bounded
//           to MAX_BURST grants. Grants are combinational; read data returns
//           one cycle after the grant.
// Ports   : clk, reset                       - clock, sync active-high reset
//           m*_req/we/addr/wdata             - requester access (held to gnt)
//           m*_gnt                           - access issued this cycle
//           m*_rvalid/m*_rdata               - read return
//           m1_lock                          - M1 burst ownership request
//           sram_EN/WE/ADDR/DI, sram_DO      - SRAM pins
//           conflict_cnt                     - saturating count of contested cycles
// Revision: 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4,
    parameter int MAX_BURST  = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [15:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [31:0]      m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [15:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic             m1_lock,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             sram_EN,
    output logic             sram_WE,
    output logic [15:0]      sram_ADDR,
    output logic [31:0]      sram_DI,
    input  logic [31:0]      sram_DO,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int BURST_W  = $clog2(MAX_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [BURST_W-1:0]  BURST_MAX  = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0]  BURST_ONE  = BURST_W'(1);

    arb_state_e          state_d, state_q;
    logic [STREAK_W-1:0] streak_d, streak_q;
    logic [BURST_W-1:0]  burst_d, burst_q;
    logic [CNT_W-1:0]    conflict_d, conflict_q;
    logic                m0_win, m1_win;
    logic                both_req;

    assign both_req = m0_req & m1_req;

    // ------------------------------------------------------------------
    // Arbitration and next-state
    // ------------------------------------------------------------------
    always_comb begin
        m0_win   = 1'b0;
        m1_win   = 1'b0;
        state_d  = state_q;
        streak_d = streak_q;
        burst_d  = burst_q;

        if (state_q == ARB_M1_LOCK && m1_req && m1_lock) begin
            if (burst_q == BURST_MAX && m0_req) begin
                // Forced release: M1 is masked for one cycle so M0 gets in.
                m0_win   = 1'b1;
                state_d  = ARB_M0_RUN;
                burst_d  = '0;
                streak_d = streak_q + 1'b1;
            end else begin
                // Still owning the burst; a full burst with no M0 waiting
                // simply starts a fresh one.
                m1_win   = 1'b1;
                streak_d = '0;
                burst_d  = (burst_q == BURST_MAX) ? BURST_ONE : burst_q + 1'b1;
            end
        end else begin
            // Normal priority arbitration; a lock that ended this cycle
            // falls through here so M0 can win immediately.
            state_d = ARB_IDLE;
            burst_d = '0;
            if (both_req) begin
                if (streak_q == STREAK_MAX) begin
                    m1_win = 1'b1;
                end else begin
                    m0_win = 1'b1;
                end
            end else if (m0_req) begin
                m0_win = 1'b1;
            end else if (m1_req) begin
                m1_win = 1'b1;
            end

            if (m0_win) begin
                state_d = ARB_M0_RUN;
                if (m1_req) begin
                    streak_d = streak_q + 1'b1;
                end
            end
            if (m1_win) begin
                streak_d = '0;
                if (m1_lock) begin
                    state_d = ARB_M1_LOCK;
                    burst_d = BURST_ONE;
                end
            end
        end
    end

    always_comb begin
        conflict_d = conflict_q;
        if (both_req && conflict_q != {CNT_W{1'b1}}) begin
            conflict_d = conflict_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            streak_q   <= '0;
            burst_q    <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            burst_q    <= burst_d;
            conflict_q <= conflict_d;
        end
    end

    // ------------------------------------------------------------------
    // Grants and SRAM pin mux (all zero when nobody is granted)
    // ------------------------------------------------------------------
    assign m0_gnt       = m0_win & ~reset;
    assign m1_gnt       = m1_win & ~reset;
    assign conflict_cnt = conflict_q;

    assign sram_EN   = m0_gnt | m1_gnt;
    assign sram_WE   = m1_gnt ? m1_we    : (m0_gnt & m0_we);
    assign sram_ADDR = m1_gnt ? m1_addr  : (m0_gnt ? m0_addr  : 16'd0);
    assign sram_DI   = m1_gnt ? m1_wdata : (m0_gnt ? m0_wdata : 32'd0);

    sram_rd_return u_rd_return (
        .clk       (clk),
        .reset     (reset),
        .rd_issue  (sram_EN & ~sram_WE),
        .rd_id     (m1_gnt ? ARB_M1 : ARB_M0),
        .sram_DO   (sram_DO),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata)
    );

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_port_arbiter
// Purpose : Randomized scoreboard bench for sram_port_arbiter. A reference
//           model predicts each cycle's grant, SRAM pin values, read return
//           and conflict count; a monitor pops and compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_port_arbiter;

    localparam int MAX_STREAK = 4;
    localparam int MAX_BURST  = 8;
    localparam int CNT_W      = 4;
    localparam int CNT_SAT    = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             r0 = 1'b1, we0 = 1'b0, r1 = 1'b1, we1 = 1'b0, l1 = 1'b0;
    logic [15:0]      a0 = 16'h0010, a1 = 16'h0011;
    logic [31:0]      d0 = '0, d1 = '0;
    logic             m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]      m0_rdata, m1_rdata;
    logic             sram_EN, sram_WE;
    logic [15:0]      sram_ADDR;
    logic [31:0]      sram_DI;
    logic [31:0]      sram_DO = '0;
    logic [CNT_W-1:0] conflict_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int mode   = 0;   // 0 contend, 1 M1 lock burst, 2 random, 3 quiet

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .MAX_STREAK (MAX_STREAK),
        .MAX_BURST  (MAX_BURST),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .m0_req       (r0),
        .m0_we        (we0),
        .m0_addr      (a0),
        .m0_wdata     (d0),
        .m0_gnt       (m0_gnt),
        .m0_rvalid    (m0_rvalid),
        .m0_rdata     (m0_rdata),
        .m1_req       (r1),
        .m1_we        (we1),
        .m1_addr      (a1),
        .m1_wdata     (d1),
        .m1_lock      (l1),
        .m1_gnt       (m1_gnt),
        .m1_rvalid    (m1_rvalid),
        .m1_rdata     (m1_rdata),
        .sram_EN      (sram_EN),
        .sram_WE      (sram_WE),
        .sram_ADDR    (sram_ADDR),
        .sram_DI      (sram_DI),
        .sram_DO      (sram_DO),
        .conflict_cnt (conflict_cnt)
    );

    function automatic logic [31:0] init_val(input logic [15:0] a);
        return {a, ~a} ^ 32'h5A5A_1234;
    endfunction

    // ---------------- SRAM behavioural model (environment) ----------------
    logic [31:0] sram_mem [logic [15:0]];
    always @(posedge clk) begin
        if (sram_EN && sram_WE) begin
            sram_mem[sram_ADDR] = sram_DI;
        end else if (sram_EN) begin
            sram_DO <= sram_mem.exists(sram_ADDR) ? sram_mem[sram_ADDR] : init_val(sram_ADDR);
        end
    end

    // ---------------- Reference model -> scoreboard queue ----------------
    typedef struct {
        logic        g0, g1, en, we;
        logic [15:0] addr;
        logic [31:0] di;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [15:0]];

    initial begin : ref_model
        int          m0_wins_in_a_row;
        bit          m1_owns;
        int          beats;
        int          pend_who;      // 0 none, 1 M0, 2 M1 read in flight
        logic [31:0] pend_data;
        int          conf;
        int          win;           // -1 none, 0 M0, 1 M1
        exp_t        e;
        m0_wins_in_a_row = 0; m1_owns = 0; beats = 0;
        pend_who = 0; pend_data = '0; conf = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e.cnt = conf;
            e.rv0 = (pend_who == 1) && !rst;
            e.rv1 = (pend_who == 2) && !rst;
            e.rd0 = e.rv0 ? pend_data : 32'd0;
            e.rd1 = e.rv1 ? pend_data : 32'd0;
            win = -1;
            if (rst) begin
                m0_wins_in_a_row = 0; m1_owns = 0; beats = 0; conf = 0;
            end else begin
                if (m1_owns && r1 && l1) begin
                    if (beats == MAX_BURST && r0) begin
                        win = 0; m1_owns = 0; beats = 0;
                        m0_wins_in_a_row++;
                    end else begin
                        win = 1; m0_wins_in_a_row = 0;
                        beats = (beats == MAX_BURST) ? 1 : beats + 1;
                    end
                end else begin
                    m1_owns = 0; beats = 0;
                    if (r0 && r1)  win = (m0_wins_in_a_row == MAX_STREAK) ? 1 : 0;
                    else if (r0)   win = 0;
                    else if (r1)   win = 1;
                    if (win == 0 && r1) m0_wins_in_a_row++;
                    if (win == 1) begin
                        m0_wins_in_a_row = 0;
                        if (l1) begin m1_owns = 1; beats = 1; end
                    end
                end
                if (r0 && r1 && conf < CNT_SAT) conf++;
            end
            e.g0 = (win == 0); e.g1 = (win == 1); e.en = (win >= 0);
            e.we = 0; e.addr = '0; e.di = '0;
            if (win == 0) begin e.we = we0; e.addr = a0; e.di = d0; end
            if (win == 1) begin e.we = we1; e.addr = a1; e.di = d1; end
            pend_who = 0;
            if (e.en && e.we) begin
                ref_mem[e.addr] = e.di;
            end else if (e.en) begin
                pend_who  = win + 1;
                pend_data = ref_mem.exists(e.addr) ? ref_mem[e.addr] : init_val(e.addr);
            end
            exp_q.push_back(e);
        end
    end

    // ---------------- Monitor ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL scoreboard_empty t=%0t actual=0 required=1", $time);
            end else begin
                e = exp_q.pop_front();
                chk("m0_gnt",    32'(m0_gnt),    32'(e.g0));
                chk("m1_gnt",    32'(m1_gnt),    32'(e.g1));
                chk("sram_EN",   32'(sram_EN),   32'(e.en));
                chk("sram_WE",   32'(sram_WE),   32'(e.we));
                chk("sram_ADDR", 32'(sram_ADDR), 32'(e.addr));
                chk("sram_DI",   sram_DI,        e.di);
                chk("m0_rvalid", 32'(m0_rvalid), 32'(e.rv0));
                chk("m1_rvalid", 32'(m1_rvalid), 32'(e.rv1));
                chk("m0_rdata",  m0_rdata,       e.rd0);
                chk("m1_rdata",  m1_rdata,       e.rd1);
                chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
            end
        end
    end

    // ---------------- Requester drivers ----------------
    initial begin : drivers
        logic        g0, g1;
        logic [15:0] burst_addr;
        burst_addr = 16'h0100;
        forever begin
            @(negedge clk);
            g0 = m0_gnt; g1 = m1_gnt;
            @(posedge clk);
            #1;
            // M0
            if (mode == 3) begin
                r0 = 0;
            end else if (g0 || !r0) begin
                we0 = 0; d0 = $urandom; a0 = 16'(16 + $urandom_range(0, 7));
                case (mode)
                    0:       r0 = 1;
                    1:       r0 = ($urandom_range(0, 5) == 0);
                    default: begin r0 = $urandom_range(0, 1); we0 = $urandom_range(0, 1); end
                endcase
            end else if (mode == 2 && $urandom_range(0, 9) == 0) begin
                r0 = 0;
            end
            // M1
            if (mode == 3) begin
                r1 = 0; l1 = 0;
            end else if (g1 || !r1) begin
                we1 = 0; d1 = $urandom; a1 = 16'(16 + $urandom_range(0, 7));
                case (mode)
                    0: begin r1 = 1; l1 = 0; end
                    1: begin r1 = 1; l1 = 1; a1 = burst_addr; burst_addr++; end
                    default: begin
                        r1  = $urandom_range(0, 1);
                        we1 = $urandom_range(0, 1);
                        if ($urandom_range(0, 3) == 0) l1 = ~l1;
                    end
                endcase
            end else if (mode == 2 && $urandom_range(0, 9) == 0) begin
                r1 = 0;
            end
        end
    end

    // ---------------- Main sequence ----------------
    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (40) @(posedge clk);
        mode = 1;
        repeat (80) @(posedge clk);
        mode = 2;
        repeat (3000) begin
            @(posedge clk);
            #1 rst = ($urandom_range(0, 79) == 0);
        end
        rst  = 0;
        mode = 3;
        repeat (6) @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
